// File: rtl/pat_field_buf.sv
// pat_field_buf: NUM_BUFS x BUF_WIDTH pattern buffers with bit-granular field read/write and a valid/ready drain port
//   clk, rst_n          clock, asynchronous active-low reset
//   bufp                buffer select for field read, field write and emit
//   fieldp, field_out   read bit offset, registered read field (1-cycle latency)
//   fieldwp, field_wr_en, field_in   write bit offset, write enable, write field
//   wrap_en             1: bits past the buffer end wrap to bit 0; 0: they are clipped
//   emit_req, emit_drop request drain of buffer bufp; pulse when the request is ignored (port busy)
//   out_valid, out_ready, out_data, out_bufid   drain port towards the pattern emitter
module pat_field_buf #(
    parameter int NUM_BUFS      = 8,
    parameter int BUF_WIDTH     = 32,
    parameter int FIELD_W       = 8,
    parameter bit CLEAR_ON_EMIT = 1'b1,
    localparam int BUFP_W       = NUM_BUFS > 1 ? $clog2(NUM_BUFS) : 1,
    localparam int FIELDP_W     = BUF_WIDTH > 1 ? $clog2(BUF_WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUFP_W-1:0]    bufp,
    input  logic [FIELDP_W-1:0]  fieldp,
    output logic [FIELD_W-1:0]   field_out,
    input  logic [FIELDP_W-1:0]  fieldwp,
    input  logic                 field_wr_en,
    input  logic [FIELD_W-1:0]   field_in,
    input  logic                 wrap_en,
    input  logic                 emit_req,
    output logic                 emit_drop,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUF_WIDTH-1:0] out_data,
    output logic [BUFP_W-1:0]    out_bufid
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state, state_nx;
    logic [BUF_WIDTH-1:0] bufs [NUM_BUFS];
    logic [BUF_WIDTH-1:0] rd_buf, wr_mask, wr_data;
    logic [FIELD_W-1:0]   rd_field;
    logic                 buf_ok, emit_go;

    function automatic logic in_range(input logic [FIELDP_W-1:0] base, input int i);
        return 32'(base) + i < BUF_WIDTH;
    endfunction

    function automatic logic [FIELDP_W-1:0] bit_pos(input logic [FIELDP_W-1:0] base, input int i);
        return FIELDP_W'((32'(base) + i) % BUF_WIDTH);
    endfunction

    // Selecting by equality leaves rd_buf at 0 and buf_ok low for an out-of-range bufp
    always_comb begin
        rd_buf = '0;
        buf_ok = 1'b0;
        for (int b = 0; b < NUM_BUFS; b++) begin
            if (bufp == BUFP_W'(b)) begin
                rd_buf = bufs[b];
                buf_ok = 1'b1;
            end
        end
    end

    // Read field from the pre-write buffer; write mask/data placed at their bit positions
    always_comb begin
        rd_field = '0;
        wr_mask  = '0;
        wr_data  = '0;
        for (int i = 0; i < FIELD_W; i++) begin
            rd_field[i] = (wrap_en || in_range(fieldp, i)) ? rd_buf[bit_pos(fieldp, i)] : 1'b0;
            if (field_wr_en && (wrap_en || in_range(fieldwp, i))) begin
                wr_mask[bit_pos(fieldwp, i)] = 1'b1;
                wr_data[bit_pos(fieldwp, i)] = field_in[i];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        emit_go   = 1'b0;
        emit_drop = 1'b0;
        emit_go   = (state == IDLE) && emit_req && buf_ok;
        emit_drop = (state == HOLD) && emit_req;
        state_nx  = emit_go ? HOLD : (state == HOLD && out_ready) ? IDLE : state;
    end

    assign out_valid = state == HOLD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            field_out <= '0;
            out_data  <= '0;
            out_bufid <= '0;
            for (int b = 0; b < NUM_BUFS; b++) bufs[b] <= '0;
        end else begin
            state     <= state_nx;
            field_out <= rd_field;
            if (emit_go) begin
                out_data  <= rd_buf;
                out_bufid <= bufp;
            end
            // Clear-on-emit happens first so a same-cycle field write survives
            for (int b = 0; b < NUM_BUFS; b++) begin
                if (bufp == BUFP_W'(b))
                    bufs[b] <= (((emit_go && CLEAR_ON_EMIT) ? '0 : bufs[b]) & ~wr_mask) | wr_data;
            end
        end
    end
endmodule
